// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine's y-stream consumers.
package conv_pkg;

  localparam int ACC_SIZE  = 21;
  localparam int NUM_Y_DEF = 97;
  localparam int POOL_DEF  = 2;

  // Pooled results per frame for the default geometry (partial window included).
  localparam int NUM_Z = (NUM_Y_DEF + POOL_DEF - 1) / POOL_DEF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One output FIFO entry: pooled value plus end-of-frame marker.
  typedef struct packed {
    logic                       last;
    logic signed [ACC_SIZE-1:0] data;
  } z_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered read port that always shows the head entry.
module fifo_sync #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4   // power of 2, at least 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic             w_push;
  logic             w_pop;

  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_rd_data    = r_rd_data;
  assign w_push       = i_push && !o_full;
  assign w_pop        = i_pop && !o_empty;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  // Storage write.
  // NOTE: the memory array carries no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count alone.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register: load the entry that will be at the head after this edge,
  // bypassing the write data when that entry is being written right now.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[w_rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/y_maxpool_stage.sv
// ReLU + non-overlapping max-pool of the conv engine's y stream, buffered into
// a small FIFO that drives a valid/ready z port with an end-of-frame marker.
module y_maxpool_stage
  import conv_pkg::*;
#(
  parameter int NUM_Y      = 97,
  parameter int POOL       = 2,   // 1..8
  parameter int FIFO_DEPTH = 4,   // power of 2, at least 2
  parameter int RELU_EN    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid_y,
  output logic                       s_ready_y,
  input  logic signed [ACC_SIZE-1:0] s_data_in_y,
  output logic                       m_valid_z,
  input  logic                       m_ready_z,
  output logic signed [ACC_SIZE-1:0] m_data_out_z,
  output logic                       m_last_z
);

  localparam int WC_W  = clog2_min1(POOL);
  localparam int YC_W  = clog2_min1(NUM_Y);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(POOL - 1);
  localparam logic [YC_W-1:0] Y_LAST   = YC_W'(NUM_Y - 1);

  logic [WC_W-1:0]            r_win_cnt;
  logic [YC_W-1:0]            r_y_cnt;
  logic signed [ACC_SIZE-1:0] r_max;

  logic                       w_accept;
  logic signed [ACC_SIZE-1:0] w_v;
  logic signed [ACC_SIZE-1:0] w_max_nxt;
  logic                       w_last_y;
  logic                       w_close;
  logic                       w_full;
  logic                       w_empty;
  logic [CNT_W-1:0]           w_count;
  logic                       w_unused_count;
  z_entry_t                   w_entry;
  z_entry_t                   w_head;

  assign w_accept  = s_valid_y && s_ready_y;
  assign w_v       = ((RELU_EN != 0) && s_data_in_y[ACC_SIZE-1]) ? '0 : s_data_in_y;
  assign w_max_nxt = (r_win_cnt == '0) ? w_v : ((w_v > r_max) ? w_v : r_max);
  assign w_last_y  = (r_y_cnt == Y_LAST);
  assign w_close   = (r_win_cnt == WIN_LAST) || w_last_y;
  assign w_entry   = '{last: w_last_y, data: w_max_nxt};

  // Full FIFO blocks every sample, even one that would not close a window.
  assign s_ready_y      = !w_full;
  assign m_valid_z      = !w_empty;
  assign m_data_out_z   = w_head.data;
  assign m_last_z       = w_head.last;
  assign w_unused_count = ^w_count;

  // Window/frame position and running maximum, advanced on each accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
      r_y_cnt   <= '0;
      r_max     <= '0;
    end else if (w_accept) begin
      r_max     <= w_max_nxt;
      r_win_cnt <= w_close ? '0 : r_win_cnt + 1'b1;
      r_y_cnt   <= w_last_y ? '0 : r_y_cnt + 1'b1;
    end
  end

  fifo_sync #(
    .WIDTH ($bits(z_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_accept && w_close),
    .i_wr_data (w_entry),
    .i_pop     (m_valid_z && m_ready_z),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule

// File: doc/y_maxpool_stage.md
Name: y_maxpool_stage

Overview:
- Downstream consumer of the convolution engine's y stream: 21-bit signed results, NUM_Y per frame, valid/ready handshake.
- Optionally applies ReLU to each sample, then max-pools non-overlapping windows of POOL samples.
- Results are buffered in a small output FIFO and presented on a valid/ready master port with an end-of-frame marker.
- Decouples the conv engine from a slow downstream consumer.

Parameters:
- ACC_SIZE, 21: width of the y input and z output data.
- NUM_Y, 97: y samples per frame (X_SIZE-F_SIZE+1 = 128-32+1).
- POOL, 2: pooling window length; legal range 1..8.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.
- RELU_EN, 1: 1 = clamp negative samples to 0 before the max; 0 = bypass.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid_y  in  1  upstream y sample valid
- s_ready_y  out  1  stage can accept a y sample
- s_data_in_y  in  ACC_SIZE  signed y sample
- m_valid_z  out  1  pooled result valid
- m_ready_z  in  1  downstream accepts the result
- m_data_out_z  out  ACC_SIZE  signed pooled result
- m_last_z  out  1  high with the final pooled result of a frame

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: s_ready_y=1, m_valid_z=0, m_data_out_z=0, m_last_z=0. Window counter, frame counter, FIFO pointers and FIFO count all clear to 0.
- Input accept: a sample is taken when s_valid_y && s_ready_y.
- Input ready: s_ready_y = (fifo_count != FIFO_DEPTH). A pop in the same cycle does not raise s_ready_y, so there is no combinational ready path.
- Sample conditioning: v = (RELU_EN && s_data_in_y<0) ? 0 : s_data_in_y.
- Window state:
  - win_cnt counts 0..POOL-1 within a window.
  - y_cnt counts 0..NUM_Y-1 within a frame.
  - On the first sample of a window, the running max is loaded with v. On later samples, max = (v > max) ? v : max, using a signed compare.
- Window close: a window closes on the accepted sample where win_cnt==POOL-1 OR y_cnt==NUM_Y-1. The partial final window is flushed.
- Push on close: {max(including v), y_cnt==NUM_Y-1} is pushed into the FIFO and win_cnt returns to 0.
- Frame end: at y_cnt==NUM_Y-1, y_cnt wraps to 0 and the next frame starts with no idle cycle.
- Results per frame: ceil(NUM_Y/POOL); 49 for the defaults.
- Latency: m_valid_z rises 1 cycle after acceptance of the closing sample, provided the FIFO was empty.
- FIFO output:
  - m_valid_z = (fifo_count != 0).
  - m_data_out_z and m_last_z show the head entry, registered from the FIFO read port.
  - A pop occurs on m_valid_z && m_ready_z.
  - Simultaneous push and pop leaves the count unchanged.
  - Output data and last must hold stable while m_valid_z && !m_ready_z.
- Back-pressure: when the FIFO is full, s_ready_y=0 and no sample is taken, even one that would not close a window. This keeps the full condition simple.
- No arithmetic growth: the output width equals the input width, so no saturation is needed.
- POOL=1: pure registered pass-through with ReLU. m_last_z is set on sample NUM_Y-1.
- Reset mid-frame: the partial window and all FIFO contents are discarded. The next accepted sample is treated as y index 0.

Decomposition:
- Package conv_pkg holds:
  - ACC_SIZE;
  - localparam NUM_Z = (NUM_Y+POOL-1)/POOL;
  - function clog2_min1(n), which returns at least 1 for counter widths;
  - typedef z_entry_t = struct packed {logic last; logic signed [ACC_SIZE-1:0] data;}.
- Sub-module fifo_sync (params WIDTH, DEPTH):
  - registered read data;
  - count output;
  - full and empty flags.
- It is reused for width ACC_SIZE+1. Pooling and counters stay in the top module.

Test Plan:
- Ramp frame: y=0..96 with valid held and m_ready_z=1 -> z = 1,3,5,...,95,96 (49 results); m_last_z only on 96; first z 1 cycle after y=1 is accepted.
- ReLU: pairs (-5,-3), (-7,4), (100,-100) -> z=0,4,100. Same input with RELU_EN=0 -> z=-3,4,100.
- Back-pressure: m_ready_z=0 for 20 cycles during the ramp -> s_ready_y drops after 4 pushes (8 samples accepted). Release -> no loss or duplication; data is held stable while stalled.
- Back-to-back frames: 194 samples with random valid gaps -> 98 results; m_last_z on results 49 and 98; second frame's first z = max(y0,y1) of the new frame.
- Reset mid-frame: reset after 33 samples with 2 results queued -> m_valid_z=0 next cycle. A fresh 97-sample frame yields exactly 49 results and the correct m_last_z.
- POOL=3, NUM_Y=97: random data -> 33 results; last result = max of the final single sample; compare against the reference model.
